// File: rtl/xbar_req_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_req_arbiter
//   N-channel request crossbar front end. Each channel has a one-entry input
//   buffer; a round-robin arbiter forwards one request per cycle into a
//   registered output stage that feeds the HTU and, for writes, the write
//   buffer. Writes are given a write-buffer ID from an internal free list.
//
// Ports
//   clk_i / rst_i                 clock, synchronous active-low reset
//   ch_req_valid_i / allowIn_o    per-channel request handshake
//   ch_req_op_i                   per-channel op (0 rd, 1 wr, 2 flush, else illegal)
//   ch_req_addr_i / data_i        per-channel address [31:4] and write data
//   xbar_htu_*                    HTU request (valid/ready, ch, opcode, addr, set, id)
//   xbar_wbuf_req_*               write-data request (valid/ready, ch, data, id)
//   wbuf_free_valid_i / id_i      write-buffer ID release
//   wbuf_free_cnt_o               number of free IDs
//   err_o                         sticky: illegal op accepted or double free
// ---------------------------------------------------------------------------
module xbar_req_arbiter #(
  parameter int unsigned CH_NUM    = 3,
  parameter int unsigned CH_ID_W   = 2,
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned SET_W     = 3,
  parameter int unsigned WBUF_NUM  = 256,
  parameter int unsigned WBUF_ID_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CH_NUM-1:0]          ch_req_valid_i,
  output logic [CH_NUM-1:0]          ch_req_allowIn_o,
  input  logic [3*CH_NUM-1:0]        ch_req_op_i,
  input  logic [ADDR_W*CH_NUM-1:0]   ch_req_addr_i,
  input  logic [DATA_W*CH_NUM-1:0]   ch_req_data_i,
  output logic                       xbar_htu_valid_o,
  input  logic                       xbar_htu_ready_i,
  output logic [CH_ID_W-1:0]         xbar_htu_ch_id_o,
  output logic [1:0]                 xbar_htu_opcode_o,
  output logic [31:0]                xbar_htu_addr_o,
  output logic [SET_W-1:0]           xbar_htu_set_o,
  output logic [WBUF_ID_W-1:0]       xbar_htu_wbuffer_id_o,
  output logic                       xbar_wbuf_req_valid_o,
  input  logic                       xbar_wbuf_req_ready_i,
  output logic [CH_ID_W-1:0]         xbar_wbuf_req_ch_id_o,
  output logic [DATA_W-1:0]          xbar_wbuf_req_data_o,
  output logic [WBUF_ID_W-1:0]       xbar_wbuf_req_wbuffer_id_o,
  input  logic                       wbuf_free_valid_i,
  input  logic [WBUF_ID_W-1:0]       wbuf_free_id_i,
  output logic [WBUF_ID_W:0]         wbuf_free_cnt_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FLUSH = 2'b10
  } op_e;

  localparam logic [WBUF_ID_W:0] CNT_ONE   = 1;
  localparam logic [WBUF_ID_W:0] CNT_RESET = WBUF_NUM;

  // input buffers
  logic [CH_NUM-1:0] buf_v_q, buf_v_d;
  op_e               buf_op_q   [CH_NUM];
  op_e               buf_op_d   [CH_NUM];
  logic [ADDR_W-1:0] buf_addr_q [CH_NUM];
  logic [ADDR_W-1:0] buf_addr_d [CH_NUM];
  logic [DATA_W-1:0] buf_data_q [CH_NUM];
  logic [DATA_W-1:0] buf_data_d [CH_NUM];

  // arbitration / free list
  logic [CH_ID_W-1:0]   last_q, last_d;
  logic [WBUF_NUM-1:0]  free_map_q, free_map_d;
  logic [WBUF_ID_W:0]   free_cnt_q, free_cnt_d;
  logic                 err_q, err_d;

  // output stage
  logic                 htu_v_q, htu_v_d;
  logic [CH_ID_W-1:0]   htu_ch_q, htu_ch_d;
  op_e                  htu_op_q, htu_op_d;
  logic [ADDR_W-1:0]    htu_addr_q, htu_addr_d;
  logic [WBUF_ID_W-1:0] htu_wid_q, htu_wid_d;
  logic                 wbuf_v_q, wbuf_v_d;
  logic [CH_ID_W-1:0]   wbuf_ch_q, wbuf_ch_d;
  logic [DATA_W-1:0]    wbuf_data_q, wbuf_data_d;
  logic [WBUF_ID_W-1:0] wbuf_wid_q, wbuf_wid_d;

  // combinational helpers
  logic                 stage_done;
  logic [CH_NUM-1:0]    eligible;
  logic [CH_NUM-1:0]    grant;
  logic                 grant_vld;
  logic [CH_ID_W-1:0]   grant_idx;
  logic                 grant_wr;
  logic [WBUF_ID_W-1:0] alloc_id;
  logic [CH_NUM-1:0]    allow;
  logic                 illegal_acc;
  logic [2:0]           req_op;
  logic                 free_ok;
  logic                 double_free;

  // The stage may take a new request when each side is empty or handshaking now.
  always_comb begin
    stage_done = (~htu_v_q | xbar_htu_ready_i) & (~wbuf_v_q | xbar_wbuf_req_ready_i);
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      eligible[i] = buf_v_q[i] & ((buf_op_q[i] != OP_WRITE) | (free_cnt_q != '0));
    end
  end

  // Round-robin: scan from the channel after the last winner.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (stage_done) begin
      for (int unsigned k = 1; k <= CH_NUM; k++) begin
        idx = (32'(last_q) + k) % CH_NUM;
        if (!grant_vld && eligible[idx]) begin
          grant_vld  = 1'b1;
          grant_idx  = CH_ID_W'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
    grant_wr = grant_vld & (buf_op_q[grant_idx] == OP_WRITE);
    last_d   = grant_vld ? grant_idx : last_q;
  end

  // Lowest-index free write-buffer ID.
  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_id = '0;
    for (int unsigned b = 0; b < WBUF_NUM; b++) begin
      if (!found && free_map_q[b]) begin
        alloc_id = WBUF_ID_W'(b);
        found    = 1'b1;
      end
    end
  end

  // Input buffers; a granted entry can be refilled in the same cycle.
  always_comb begin
    illegal_acc = 1'b0;
    req_op      = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      allow[i]      = rst_i & (~buf_v_q[i] | grant[i]);
      buf_v_d[i]    = buf_v_q[i] & ~grant[i];
      buf_op_d[i]   = buf_op_q[i];
      buf_addr_d[i] = buf_addr_q[i];
      buf_data_d[i] = buf_data_q[i];
      req_op        = ch_req_op_i[3*i +: 3];
      if (ch_req_valid_i[i] && allow[i]) begin
        if (req_op <= 3'd2) begin
          buf_v_d[i]    = 1'b1;
          buf_op_d[i]   = op_e'(req_op[1:0]);
          buf_addr_d[i] = ch_req_addr_i[ADDR_W*i +: ADDR_W];
          buf_data_d[i] = ch_req_data_i[DATA_W*i +: DATA_W];
        end else begin
          illegal_acc = 1'b1;
        end
      end
    end
  end

  // Free list bitmap, counter and sticky error.
  always_comb begin
    double_free = wbuf_free_valid_i & free_map_q[wbuf_free_id_i];
    free_ok     = wbuf_free_valid_i & ~free_map_q[wbuf_free_id_i];
    free_map_d  = free_map_q;
    if (grant_wr) free_map_d[alloc_id] = 1'b0;
    if (free_ok)  free_map_d[wbuf_free_id_i] = 1'b1;
    free_cnt_d = free_cnt_q;
    if (grant_wr && !free_ok) begin
      free_cnt_d = free_cnt_q - CNT_ONE;
    end else if (free_ok && !grant_wr) begin
      free_cnt_d = free_cnt_q + CNT_ONE;
    end
    err_d = err_q | illegal_acc | double_free;
  end

  // Output stage: each valid retires on its own handshake; a grant reloads.
  always_comb begin
    htu_v_d     = htu_v_q & ~xbar_htu_ready_i;
    htu_ch_d    = htu_ch_q;
    htu_op_d    = htu_op_q;
    htu_addr_d  = htu_addr_q;
    htu_wid_d   = htu_wid_q;
    wbuf_v_d    = wbuf_v_q & ~xbar_wbuf_req_ready_i;
    wbuf_ch_d   = wbuf_ch_q;
    wbuf_data_d = wbuf_data_q;
    wbuf_wid_d  = wbuf_wid_q;
    if (grant_vld) begin
      htu_v_d    = 1'b1;
      htu_ch_d   = grant_idx;
      htu_op_d   = buf_op_q[grant_idx];
      htu_addr_d = buf_addr_q[grant_idx];
      htu_wid_d  = grant_wr ? alloc_id : '0;
      if (grant_wr) begin
        wbuf_v_d    = 1'b1;
        wbuf_ch_d   = grant_idx;
        wbuf_data_d = buf_data_q[grant_idx];
        wbuf_wid_d  = alloc_id;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      buf_v_q     <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        buf_op_q[i]   <= OP_READ;
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
      last_q      <= CH_ID_W'(CH_NUM - 1);
      free_map_q  <= '1;
      free_cnt_q  <= CNT_RESET;
      err_q       <= 1'b0;
      htu_v_q     <= 1'b0;
      htu_ch_q    <= '0;
      htu_op_q    <= OP_READ;
      htu_addr_q  <= '0;
      htu_wid_q   <= '0;
      wbuf_v_q    <= 1'b0;
      wbuf_ch_q   <= '0;
      wbuf_data_q <= '0;
      wbuf_wid_q  <= '0;
    end else begin
      buf_v_q     <= buf_v_d;
      buf_op_q    <= buf_op_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      last_q      <= last_d;
      free_map_q  <= free_map_d;
      free_cnt_q  <= free_cnt_d;
      err_q       <= err_d;
      htu_v_q     <= htu_v_d;
      htu_ch_q    <= htu_ch_d;
      htu_op_q    <= htu_op_d;
      htu_addr_q  <= htu_addr_d;
      htu_wid_q   <= htu_wid_d;
      wbuf_v_q    <= wbuf_v_d;
      wbuf_ch_q   <= wbuf_ch_d;
      wbuf_data_q <= wbuf_data_d;
      wbuf_wid_q  <= wbuf_wid_d;
    end
  end

  assign ch_req_allowIn_o           = allow;
  assign xbar_htu_valid_o           = htu_v_q;
  assign xbar_htu_ch_id_o           = htu_ch_q;
  assign xbar_htu_opcode_o          = htu_op_q;
  assign xbar_htu_addr_o            = 32'({htu_addr_q, 4'b0000});
  assign xbar_htu_set_o             = htu_addr_q[SET_W-1:0];
  assign xbar_htu_wbuffer_id_o      = htu_wid_q;
  assign xbar_wbuf_req_valid_o      = wbuf_v_q;
  assign xbar_wbuf_req_ch_id_o      = wbuf_ch_q;
  assign xbar_wbuf_req_data_o       = wbuf_data_q;
  assign xbar_wbuf_req_wbuffer_id_o = wbuf_wid_q;
  assign wbuf_free_cnt_o            = free_cnt_q;
  assign err_o                      = err_q;

endmodule

// File: tb/tb_xbar_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbar_req_arbiter
//   Directed scenarios followed by a randomized phase. A transaction-level
//   reference model (per-channel slots, last-winner integer, free-ID vector
//   counted with $countones) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_xbar_req_arbiter;

  localparam int unsigned CH  = 3;
  localparam int unsigned IDW = 2;
  localparam int unsigned AW  = 28;
  localparam int unsigned DW  = 128;
  localparam int unsigned SW  = 3;
  localparam int unsigned WN  = 256;
  localparam int unsigned WIW = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_i;
  logic [CH-1:0]     ch_req_valid_i;
  logic [CH-1:0]     ch_req_allowIn_o;
  logic [3*CH-1:0]   ch_req_op_i;
  logic [AW*CH-1:0]  ch_req_addr_i;
  logic [DW*CH-1:0]  ch_req_data_i;
  logic              xbar_htu_valid_o;
  logic              xbar_htu_ready_i;
  logic [IDW-1:0]    xbar_htu_ch_id_o;
  logic [1:0]        xbar_htu_opcode_o;
  logic [31:0]       xbar_htu_addr_o;
  logic [SW-1:0]     xbar_htu_set_o;
  logic [WIW-1:0]    xbar_htu_wbuffer_id_o;
  logic              xbar_wbuf_req_valid_o;
  logic              xbar_wbuf_req_ready_i;
  logic [IDW-1:0]    xbar_wbuf_req_ch_id_o;
  logic [DW-1:0]     xbar_wbuf_req_data_o;
  logic [WIW-1:0]    xbar_wbuf_req_wbuffer_id_o;
  logic              wbuf_free_valid_i;
  logic [WIW-1:0]    wbuf_free_id_i;
  logic [WIW:0]      wbuf_free_cnt_o;
  logic              err_o;

  xbar_req_arbiter #(
    .CH_NUM(CH), .CH_ID_W(IDW), .ADDR_W(AW), .DATA_W(DW),
    .SET_W(SW), .WBUF_NUM(WN), .WBUF_ID_W(WIW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ch_req_valid_i(ch_req_valid_i), .ch_req_allowIn_o(ch_req_allowIn_o),
    .ch_req_op_i(ch_req_op_i), .ch_req_addr_i(ch_req_addr_i), .ch_req_data_i(ch_req_data_i),
    .xbar_htu_valid_o(xbar_htu_valid_o), .xbar_htu_ready_i(xbar_htu_ready_i),
    .xbar_htu_ch_id_o(xbar_htu_ch_id_o), .xbar_htu_opcode_o(xbar_htu_opcode_o),
    .xbar_htu_addr_o(xbar_htu_addr_o), .xbar_htu_set_o(xbar_htu_set_o),
    .xbar_htu_wbuffer_id_o(xbar_htu_wbuffer_id_o),
    .xbar_wbuf_req_valid_o(xbar_wbuf_req_valid_o), .xbar_wbuf_req_ready_i(xbar_wbuf_req_ready_i),
    .xbar_wbuf_req_ch_id_o(xbar_wbuf_req_ch_id_o), .xbar_wbuf_req_data_o(xbar_wbuf_req_data_o),
    .xbar_wbuf_req_wbuffer_id_o(xbar_wbuf_req_wbuffer_id_o),
    .wbuf_free_valid_i(wbuf_free_valid_i), .wbuf_free_id_i(wbuf_free_id_i),
    .wbuf_free_cnt_o(wbuf_free_cnt_o), .err_o(err_o)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  // reference model state
  bit            m_bv    [CH];
  int            m_bop   [CH];
  logic [AW-1:0] m_baddr [CH];
  logic [DW-1:0] m_bdata [CH];
  int            m_last;
  logic [WN-1:0] m_free;
  bit            m_err;
  bit            m_hv, m_wv;
  int            m_hch, m_hop, m_hwid, m_wch, m_wwid;
  logic [31:0]   m_haddr;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_bv[i] = 0; m_bop[i] = 0; m_baddr[i] = '0; m_bdata[i] = '0;
    end
    m_last = CH - 1;
    m_free = '1;
    m_err  = 0;
    m_hv = 0; m_wv = 0;
    m_hch = 0; m_hop = 0; m_hwid = 0; m_wch = 0; m_wwid = 0;
    m_haddr = '0; m_wdata = '0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input int ch, input logic [2:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    ch_req_valid_i[ch]         = 1'b1;
    ch_req_op_i[3*ch +: 3]     = op;
    ch_req_addr_i[AW*ch +: AW] = a;
    ch_req_data_i[DW*ch +: DW] = d;
  endtask

  // One clock: compare DUT against model at negedge, advance model, return #1 after posedge.
  task automatic step();
    int            g, cnt, id, c;
    logic [CH-1:0] ea;
    logic [WN-1:0] pre;
    logic [2:0]    op;
    @(negedge clk_i);
    chk("htu_valid", xbar_htu_valid_o, m_hv);
    chk("wbuf_valid", xbar_wbuf_req_valid_o, m_wv);
    chk("free_cnt", wbuf_free_cnt_o, $countones(m_free));
    chk("err", err_o, m_err);
    if (m_hv) begin
      chk("htu_ch", xbar_htu_ch_id_o, m_hch);
      chk("htu_opcode", xbar_htu_opcode_o, m_hop);
      chk("htu_addr", xbar_htu_addr_o, m_haddr);
      chk("htu_set", xbar_htu_set_o, m_haddr[SW+3:4]);
      chk("htu_wid", xbar_htu_wbuffer_id_o, m_hwid);
    end
    if (m_wv) begin
      chk("wbuf_ch", xbar_wbuf_req_ch_id_o, m_wch);
      chk("wbuf_data", xbar_wbuf_req_data_o, m_wdata);
      chk("wbuf_wid", xbar_wbuf_req_wbuffer_id_o, m_wwid);
    end
    cnt = $countones(m_free);
    g = -1;
    if (rst_i && (!m_hv || xbar_htu_ready_i) && (!m_wv || xbar_wbuf_req_ready_i)) begin
      for (int k = 1; k <= CH; k++) begin
        c = (m_last + k) % CH;
        if (g < 0 && m_bv[c] && (m_bop[c] != 1 || cnt > 0)) g = c;
      end
    end
    for (int i = 0; i < CH; i++) ea[i] = rst_i && (!m_bv[i] || g == i);
    chk("allowIn", ch_req_allowIn_o, ea);
    if (!rst_i) begin
      m_reset();
    end else begin
      pre = m_free;
      if (m_hv && xbar_htu_ready_i) m_hv = 0;
      if (m_wv && xbar_wbuf_req_ready_i) m_wv = 0;
      if (g >= 0) begin
        m_hv = 1; m_hch = g; m_hop = m_bop[g];
        m_haddr = {m_baddr[g], 4'h0}; m_hwid = 0;
        if (m_bop[g] == 1) begin
          id = 0;
          for (int b = 0; b < WN; b++) if (pre[b]) begin id = b; break; end
          m_free[id] = 1'b0;
          m_hwid = id; m_wv = 1; m_wch = g; m_wdata = m_bdata[g]; m_wwid = id;
        end
        m_bv[g] = 0;
        m_last = g;
      end
      if (wbuf_free_valid_i) begin
        if (pre[wbuf_free_id_i]) m_err = 1;
        else m_free[wbuf_free_id_i] = 1'b1;
      end
      for (int i = 0; i < CH; i++) begin
        if (ch_req_valid_i[i] && ea[i]) begin
          op = ch_req_op_i[3*i +: 3];
          if (op > 3'd2) m_err = 1;
          else begin
            m_bv[i] = 1; m_bop[i] = int'(op);
            m_baddr[i] = ch_req_addr_i[AW*i +: AW];
            m_bdata[i] = ch_req_data_i[DW*i +: DW];
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    int            st, fid;
    bit            fnd;

    rst_i = 1'b0;
    ch_req_valid_i = '0; ch_req_op_i = '0; ch_req_addr_i = '0; ch_req_data_i = '0;
    xbar_htu_ready_i = 1'b1; xbar_wbuf_req_ready_i = 1'b1;
    wbuf_free_valid_i = 1'b0; wbuf_free_id_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    m_reset();
    step();
    chk("rst_allow", ch_req_allowIn_o, '0);
    chk("rst_cnt", wbuf_free_cnt_o, 256);
    chk("rst_htu_v", xbar_htu_valid_o, 0);
    chk("rst_addr", xbar_htu_addr_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b1;

    // single read from ch1
    drive(1, 3'd0, 28'h0000123, rnd_data());
    step();
    ch_req_valid_i = '0;
    step();
    chk("t1_valid", xbar_htu_valid_o, 1);
    chk("t1_ch", xbar_htu_ch_id_o, 1);
    chk("t1_opcode", xbar_htu_opcode_o, 0);
    chk("t1_addr", xbar_htu_addr_o, 32'h0000_1230);
    chk("t1_set", xbar_htu_set_o, 3'b011);
    chk("t1_wid", xbar_htu_wbuffer_id_o, 0);
    repeat (2) step();

    // all channels streaming reads: strict rotation
    do_reset();
    for (int i = 0; i < CH; i++) drive(i, 3'd0, AW'($urandom), rnd_data());
    step();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < CH; i++) drive(i, 3'd0, AW'($urandom), rnd_data());
      step();
      chk("rr_valid", xbar_htu_valid_o, 1);
      chk("rr_order", xbar_htu_ch_id_o, k % CH);
    end
    ch_req_valid_i = '0;
    repeat (4) step();

    // write with stalled write buffer
    do_reset();
    xbar_wbuf_req_ready_i = 1'b0;
    drive(2, 3'd1, AW'($urandom), rnd_data());
    step();
    ch_req_valid_i = '0;
    step();
    held = xbar_wbuf_req_data_o;
    chk("wr_htu_v", xbar_htu_valid_o, 1);
    chk("wr_wbuf_v", xbar_wbuf_req_valid_o, 1);
    chk("wr_wid", xbar_wbuf_req_wbuffer_id_o, 0);
    chk("wr_cnt", wbuf_free_cnt_o, 255);
    drive(0, 3'd0, AW'($urandom), rnd_data());
    for (int k = 0; k < 3; k++) begin
      step();
      ch_req_valid_i = '0;
      chk("hold_htu_v", xbar_htu_valid_o, 0);
      chk("hold_wbuf_v", xbar_wbuf_req_valid_o, 1);
      chk("hold_data", xbar_wbuf_req_data_o, held);
    end
    xbar_wbuf_req_ready_i = 1'b1;
    step();
    chk("rel_wbuf_v", xbar_wbuf_req_valid_o, 0);
    chk("rel_htu_ch", xbar_htu_ch_id_o, 0);
    chk("rel_htu_v", xbar_htu_valid_o, 1);
    repeat (2) step();

    // exhaust the free list, then reads bypass the stalled write
    do_reset();
    for (int n = 0; n < 300 && $countones(m_free) != 0; n++) begin
      drive(0, 3'd1, AW'($urandom), rnd_data());
      step();
    end
    ch_req_valid_i = '0;
    chk("ex_cnt", wbuf_free_cnt_o, 0);
    drive(1, 3'd0, AW'($urandom), rnd_data());
    step();
    ch_req_valid_i = '0;
    step();
    chk("ex_rd_v", xbar_htu_valid_o, 1);
    chk("ex_rd_ch", xbar_htu_ch_id_o, 1);
    step();
    chk("ex_stall", xbar_htu_valid_o, 0);
    chk("ex_allow0", ch_req_allowIn_o[0], 0);
    wbuf_free_valid_i = 1'b1; wbuf_free_id_i = 8'd17;
    step();
    wbuf_free_valid_i = 1'b0;
    chk("ex_cnt1", wbuf_free_cnt_o, 1);
    step();
    chk("ex_wr_v", xbar_htu_valid_o, 1);
    chk("ex_wr_op", xbar_htu_opcode_o, 2'b01);
    chk("ex_wr_wid", xbar_htu_wbuffer_id_o, 17);
    chk("ex_cnt0", wbuf_free_cnt_o, 0);
    repeat (2) step();

    // double free
    do_reset();
    wbuf_free_valid_i = 1'b1; wbuf_free_id_i = 8'd5;
    step();
    wbuf_free_valid_i = 1'b0;
    chk("df_err", err_o, 1);
    chk("df_cnt", wbuf_free_cnt_o, 256);
    step();
    chk("df_sticky", err_o, 1);

    // illegal op
    do_reset();
    drive(0, 3'b111, AW'($urandom), rnd_data());
    step();
    ch_req_valid_i = '0;
    repeat (2) step();
    chk("ill_err", err_o, 1);
    chk("ill_fwd", xbar_htu_valid_o, 0);

    // reset with a pending write-buffer transfer
    do_reset();
    xbar_wbuf_req_ready_i = 1'b0;
    drive(1, 3'd1, AW'($urandom), rnd_data());
    step();
    ch_req_valid_i = '0;
    step();
    chk("mr_pending", xbar_wbuf_req_valid_o, 1);
    rst_i = 1'b0;
    ch_req_valid_i = '1;
    step();
    chk("mr_htu_v", xbar_htu_valid_o, 0);
    chk("mr_wbuf_v", xbar_wbuf_req_valid_o, 0);
    chk("mr_cnt", wbuf_free_cnt_o, 256);
    chk("mr_allow", ch_req_allowIn_o, '0);
    ch_req_valid_i = '0;
    rst_i = 1'b1;
    xbar_wbuf_req_ready_i = 1'b1;
    step();

    // randomized traffic against the model
    for (int n = 0; n < 1200; n++) begin
      rst_i = ($urandom_range(0, 299) != 0);
      xbar_htu_ready_i      = ($urandom_range(0, 3) != 0);
      xbar_wbuf_req_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < CH; i++) begin
        st = $urandom_range(0, 39);
        drive(i, (st < 16) ? 3'd0 : (st < 30) ? 3'd1 : (st < 38) ? 3'd2 : 3'($urandom_range(3, 7)),
              AW'($urandom), rnd_data());
        ch_req_valid_i[i] = $urandom_range(0, 1);
      end
      wbuf_free_valid_i = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        wbuf_free_valid_i = 1'b1;
        wbuf_free_id_i    = WIW'($urandom);
      end else if ($urandom_range(0, 2) == 0) begin
        st  = $urandom_range(0, WN - 1);
        fnd = 0;
        fid = 0;
        for (int k = 0; k < WN; k++) begin
          if (!fnd && !m_free[(st + k) % WN]) begin
            fnd = 1;
            fid = (st + k) % WN;
          end
        end
        wbuf_free_valid_i = fnd;
        wbuf_free_id_i    = WIW'(fid);
      end
      step();
    end
    ch_req_valid_i = '0;
    wbuf_free_valid_i = 1'b0;
    rst_i = 1'b1;
    xbar_htu_ready_i = 1'b1;
    xbar_wbuf_req_ready_i = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xbar_req_arbiter.md
Name: xbar_req_arbiter

Overview:
Parametrised N-channel request crossbar front end, successor to the fixed 3-channel cross bar core. Buffers one request per channel and arbitrates round-robin among channels. Forwards the winner to the HTU through a registered output stage. Write requests additionally get a write-buffer ID from an internal free list, and their data is pushed to the write buffer.

Parameters:
CH_NUM, 3, number of request channels (2..8)
CH_ID_W, 2, width of channel ID, >= clog2(CH_NUM)
ADDR_W, 28, request address width (byte address bits [31:4])
DATA_W, 128, write data width
SET_W, 3, set index width, taken from address bits [SET_W+3:4]
WBUF_NUM, 256, number of write-buffer entries
WBUF_ID_W, 8, clog2(WBUF_NUM)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-low
ch_req_valid_i  in  CH_NUM  per-channel request valid
ch_req_allowIn_o  out  CH_NUM  per-channel request accept
ch_req_op_i  in  3*CH_NUM  per-channel op, channel i at [3i+2:3i]
ch_req_addr_i  in  ADDR_W*CH_NUM  per-channel address [31:4]
ch_req_data_i  in  DATA_W*CH_NUM  per-channel write data
xbar_htu_valid_o  out  1  HTU request valid
xbar_htu_ready_i  in  1  HTU ready
xbar_htu_ch_id_o  out  CH_ID_W  source channel
xbar_htu_opcode_o  out  2  00 read, 01 write, 10 flush
xbar_htu_addr_o  out  32  {addr, 4'b0}
xbar_htu_set_o  out  SET_W  set index
xbar_htu_wbuffer_id_o  out  WBUF_ID_W  allocated ID for writes, 0 otherwise
xbar_wbuf_req_valid_o  out  1  write data valid
xbar_wbuf_req_ready_i  in  1  write buffer ready
xbar_wbuf_req_ch_id_o  out  CH_ID_W  source channel
xbar_wbuf_req_data_o  out  DATA_W  write data
xbar_wbuf_req_wbuffer_id_o  out  WBUF_ID_W  same ID as the HTU side
wbuf_free_valid_i  in  1  one write-buffer ID released this cycle
wbuf_free_id_i  in  WBUF_ID_W  released ID
wbuf_free_cnt_o  out  WBUF_ID_W+1  number of free IDs
err_o  out  1  sticky: illegal op, or double free

Behaviour:
- Reset (rst_i=0 at clock edge) clears:
  - all input buffers and the output stage;
  - all valid outputs, which go to 0;
  - all data and ID outputs, which go to 0;
  - err_o, which goes to 0;
  - the free bitmap, which is set to all 1; wbuf_free_cnt_o=WBUF_NUM;
  - the round-robin pointer, which is set so channel 0 has highest priority.
  - ch_req_allowIn_o is held 0 while rst_i=0. Reset mid-transfer drops all in-flight requests.
- Input stage: one entry per channel. Channel i accepts on ch_req_valid_i[i] & ch_req_allowIn_o[i]. ch_req_allowIn_o[i] = ~buf_v[i] | grant[i], so each channel sustains 1 request/cycle.
- Op decode at accept:
  - op 0 = read, 1 = write, 2 = flush.
  - op 3..7: request is accepted and discarded (not buffered), and err_o is set.
- Eligibility:
  - read and flush entries are eligible whenever buffered;
  - a write entry is eligible only when wbuf_free_cnt_o != 0.
- Grant: one per cycle, only when the output stage is empty or is completing this cycle. Pick the first eligible channel starting at (last_grant+1) mod CH_NUM. The pointer updates only on a grant.
- Output stage (registered, 1-cycle latency from buffer to output valid):
  - A read/flush loads xbar_htu_valid_o=1 only.
  - A write loads both xbar_htu_valid_o=1 and xbar_wbuf_req_valid_o=1.
  - Each valid drops independently on its own handshake (valid & ready).
  - The stage is complete when both valids are 0, or will be 0 after this edge.
  - Outputs are held stable while their valid is high and ready is low.
- ID allocation:
  - On grant of a write, pick the lowest-index set bit of the free bitmap, clear it, and place its index on both ID outputs.
  - wbuf_free_valid_i sets bit wbuf_free_id_i.
  - Freeing an already-free ID leaves the bitmap unchanged and sets err_o.
- Free count: wbuf_free_cnt_o = popcount of the bitmap, maintained as a counter.
  - Allocation and free in the same cycle leave the count unchanged.
  - At count 0, writes stall while reads and flushes keep flowing.
- Set index = addr[SET_W+3:4].

Test Plan:
- Reset, then a read from ch1 with addr[31:4]=0x0000123 -> one cycle later xbar_htu_valid_o=1, ch_id=1, opcode=00, addr=0x00001230, set=3'b011, wbuffer_id=0.
- All 3 channels request continuously with htu_ready=1 -> grants ch0,ch1,ch2,ch0,...; each channel sees allowIn=1 every cycle that it is granted.
- Write on ch2 with wbuf_ready=0 for 4 cycles and htu_ready=1 -> the HTU side completes at once; wbuf_valid is held for 4 cycles with ID 0 and data stable; no new grant until the wbuf handshake; free_cnt=255.
- Allocate all 256 IDs, then issue a write on ch0 and a read on ch1 -> the read is forwarded and the write stalls. A free of ID 17 -> the write gets ID 17 and free_cnt goes 1→0.
- Free of ID 5 while it is already free -> err_o=1 sticky, free_cnt unchanged. Op=3'b111 on ch0 -> accepted, not forwarded, err_o=1.
- rst_i=0 while a write is pending on the wbuf side -> the next cycle all valids are 0, free_cnt=256, allowIn=0 until rst_i=1.
